// File: rtl/order_mem_arbiter.sv
// ============================================================================
// order_mem_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter and sequencer that shares one order-book memory port
// among NUM_REQ requesters. Only one transaction is in flight at a time. The
// block drives the memory's write_request / data_read / out_valid protocol and
// returns read data to the requester that owns the transaction. A read that
// gets no answer within RD_TMO cycles completes with an error response.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   req_valid[i]        requester i has a request pending
//   req_write[i]        1 = write, 0 = read
//   req_addr / wdata    requester i at [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W]
//   req_ready[i]        one-hot accept pulse, combinational in the grant cycle
//   rsp_valid[i]        one-hot read response valid
//   rsp_ready[i]        requester i consumes its response
//   rsp_data, rsp_err   read data (0 on error) and timeout flag
//   mem_*               memory port (address_in, data_in, write_request,
//                       data_read, data_out, out_valid)
//   busy                FSM is not in IDLE
//
// Handshakes
//   Request: a request is accepted in the cycle where req_valid[i] and
//   req_ready[i] are both 1; req_ready is only ever raised for one requester
//   and only in IDLE. Response: rsp_valid[g] stays high with rsp_data/rsp_err
//   stable until the cycle where rsp_ready[g] is also 1; rsp_ready bits of
//   other requesters are ignored.
// ============================================================================
module order_mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int RD_TMO  = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_err,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_write_request,
    output logic                        mem_data_read,
    input  logic [DATA_W-1:0]           mem_data_out,
    input  logic                        mem_out_valid,
    output logic                        busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(RD_TMO + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] TMO_CNT  = CNT_W'(RD_TMO);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_WAIT = 3'd2,
        RSP     = 3'd3,
        FLUSH   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Round-robin pointer: the requester with highest priority next time.
    logic [IDX_W-1:0]  ptr;

    // Latched transaction.
    logic [IDX_W-1:0]  lat_g;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // Read bookkeeping.
    logic [CNT_W-1:0]  rd_cnt;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    // Grant selection.
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_fire;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              rsp_ack;
    logic              rd_timeout;

    // ------------------------------------------------------------------------
    // Round-robin scan: first set req_valid starting at ptr, wrapping around.
    // The sum is one bit wider than the index so the wrap works for any
    // NUM_REQ, not just powers of two.
    // ------------------------------------------------------------------------
    always_comb begin
        logic [IDX_W:0] sum;
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= NUM_EXT) begin
                sum = sum - NUM_EXT;
            end
            if (!grant_found && req_valid[sum[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[IDX_W-1:0];
            end
        end
    end

    // Stale memory data in IDLE is flushed before anything is granted.
    assign grant_fire = (state == IDLE) && !mem_out_valid && grant_found;

    // Mux the granted requester's fields out of the flat buses.
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rsp_ack    = |(rsp_ready & rsp_valid);
    assign rd_timeout = (rd_cnt == TMO_CNT);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_out_valid) begin
                    state_nxt = FLUSH;
                end else if (grant_found) begin
                    state_nxt = sel_write ? WR : RD_WAIT;
                end
            end
            WR: begin
                state_nxt = IDLE;
            end
            RD_WAIT: begin
                if (mem_out_valid || rd_timeout) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                if (rsp_ack) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers: grant latch, round-robin pointer, read counter and
    // response capture.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            lat_g      <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rd_cnt     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (grant_fire) begin
                lat_g     <= grant_idx;
                lat_write <= sel_write;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                ptr       <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                // First RD_WAIT cycle counts as 1.
                rd_cnt    <= CNT_W'(1);
            end else if (state == RD_WAIT) begin
                if (mem_out_valid) begin
                    rsp_data_q <= mem_data_out;
                    rsp_err_q  <= 1'b0;
                end else if (rd_timeout) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        req_ready         = '0;
        rsp_valid         = '0;
        rsp_data          = '0;
        rsp_err           = 1'b0;
        mem_write_request = 1'b0;
        mem_data_read     = 1'b0;
        // Address/data simply follow the latch, so they hold their last value
        // outside WR and RD_WAIT and read 0 after reset.
        mem_addr          = lat_addr;
        mem_wdata         = lat_wdata;
        busy              = (state != IDLE);

        case (state)
            IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_fire && (grant_idx == IDX_W'(i))) begin
                        req_ready[i] = 1'b1;
                    end
                end
            end
            WR: begin
                mem_write_request = 1'b1;
            end
            RD_WAIT: begin
                // Consume pulse coincides with the data being captured.
                mem_data_read = mem_out_valid;
            end
            RSP: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (lat_g == IDX_W'(i)) begin
                        rsp_valid[i] = 1'b1;
                    end
                end
                rsp_data = rsp_data_q;
                rsp_err  = rsp_err_q;
            end
            FLUSH: begin
                mem_data_read = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // lat_write is kept for debug visibility of the in-flight transaction.
    logic unused_lat_write;
    assign unused_lat_write = lat_write;

endmodule

// File: tb/tb_order_mem_arbiter.sv
// ============================================================================
// tb_order_mem_arbiter
// Directed bench for order_mem_arbiter (NUM_REQ=2, ADDR_W=12, DATA_W=32,
// RD_TMO=15). Inputs change 1 time unit after a rising edge; outputs are
// checked 1 more unit later, well away from the next edge.
// ============================================================================
module tb_order_mem_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int RD_TMO  = 15;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic                      mem_write_request;
    logic                      mem_data_read;
    logic [DATA_W-1:0]         mem_data_out;
    logic                      mem_out_valid;
    logic                      busy;

    int checks = 0;
    int errors = 0;

    order_mem_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_TMO (RD_TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_write_request(mem_write_request),
        .mem_data_read    (mem_data_read),
        .mem_data_out     (mem_data_out),
        .mem_out_valid    (mem_out_valid),
        .busy             (busy)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_rdy"},   64'(req_ready), 64'd0);
        chk({tag, "_rspv"},  64'(rsp_valid), 64'd0);
        chk({tag, "_wreq"},  64'(mem_write_request), 64'd0);
        chk({tag, "_drd"},   64'(mem_data_read), 64'd0);
        chk({tag, "_maddr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mwd"},   64'(mem_wdata), 64'd0);
        chk({tag, "_rdata"}, 64'(rsp_data), 64'd0);
        chk({tag, "_rerr"},  64'(rsp_err), 64'd0);
    endtask

    initial begin
        logic [1:0]  exp_g;
        rst           = 1'b1;
        req_valid     = '0;
        req_write     = '0;
        req_addr      = '0;
        req_wdata     = '0;
        rsp_ready     = '0;
        mem_data_out  = '0;
        mem_out_valid = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();

        // ---------------- 1: req0 write ----------------
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr[0 +: ADDR_W]  = 12'h010;
        req_wdata[0 +: DATA_W] = 32'hDEADBEEF;
        settle();
        chk("t1_ready_T", 64'(req_ready), 64'h1);
        chk("t1_wreq_T", 64'(mem_write_request), 64'h0);
        step();
        req_valid = 2'b00;
        settle();
        chk("t1_wreq_T1", 64'(mem_write_request), 64'h1);
        chk("t1_addr_T1", 64'(mem_addr), 64'h010);
        chk("t1_data_T1", 64'(mem_wdata), 64'hDEADBEEF);
        chk("t1_busy_T1", 64'(busy), 64'h1);
        chk("t1_ready_T1", 64'(req_ready), 64'h0);
        step();
        chk("t1_busy_T2", 64'(busy), 64'h0);
        chk("t1_wreq_T2", 64'(mem_write_request), 64'h0);
        chk("t1_addr_hold", 64'(mem_addr), 64'h010);

        // ---------------- 2: req1 read, answer 3 cycles later ----------------
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr[ADDR_W +: ADDR_W] = 12'h010;
        settle();
        chk("t2_ready", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        settle();
        chk("t2_wait_busy", 64'(busy), 64'h1);
        chk("t2_wait_addr", 64'(mem_addr), 64'h010);
        chk("t2_wait_wreq", 64'(mem_write_request), 64'h0);
        chk("t2_wait_drd", 64'(mem_data_read), 64'h0);
        step();
        step();
        mem_out_valid = 1'b1;
        mem_data_out  = 32'hDEADBEEF;
        settle();
        chk("t2_drd_pulse", 64'(mem_data_read), 64'h1);
        chk("t2_rspv_early", 64'(rsp_valid), 64'h0);
        step();
        mem_out_valid = 1'b0;
        mem_data_out  = 32'h0;
        rsp_ready     = 2'b01;  // wrong requester, must be ignored
        settle();
        chk("t2_drd_after", 64'(mem_data_read), 64'h0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_rspv_%0d", k), 64'(rsp_valid), 64'h2);
            chk($sformatf("t2_rdata_%0d", k), 64'(rsp_data), 64'hDEADBEEF);
            chk($sformatf("t2_rerr_%0d", k), 64'(rsp_err), 64'h0);
            step();
        end
        rsp_ready = 2'b10;
        settle();
        chk("t2_rspv_ack", 64'(rsp_valid), 64'h2);
        step();
        rsp_ready = 2'b00;
        settle();
        chk("t2_rspv_done", 64'(rsp_valid), 64'h0);
        chk("t2_busy_done", 64'(busy), 64'h0);

        // ---------------- 3: both requesting, 6 writes ----------------
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr[0 +: ADDR_W]       = 12'h100;
        req_addr[ADDR_W +: ADDR_W]  = 12'h101;
        req_wdata[0 +: DATA_W]      = 32'hA0000000;
        req_wdata[DATA_W +: DATA_W] = 32'hA0000001;
        for (int k = 0; k < 6; k++) begin
            exp_g = ((k % 2) == 0) ? 2'b01 : 2'b10;
            settle();
            chk($sformatf("t3_grant_%0d", k), 64'(req_ready), 64'(exp_g));
            step();
            chk($sformatf("t3_wreq_%0d", k), 64'(mem_write_request), 64'h1);
            chk($sformatf("t3_addr_%0d", k), 64'(mem_addr), 64'h100 + 64'(k % 2));
            chk($sformatf("t3_data_%0d", k), 64'(mem_wdata), 64'hA0000000 + 64'(k % 2));
            chk($sformatf("t3_rdy_wr_%0d", k), 64'(req_ready), 64'h0);
            step();
        end
        req_valid = 2'b00;

        // ---------------- 4: read timeout ----------------
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[0 +: ADDR_W] = 12'h020;
        settle();
        chk("t4_ready", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        settle();
        chk("t4_cnt1_rspv", 64'(rsp_valid), 64'h0);
        for (int k = 2; k <= RD_TMO; k++) begin
            step();
            chk($sformatf("t4_cnt%0d_rspv", k), 64'(rsp_valid), 64'h0);
        end
        chk("t4_cnt15_busy", 64'(busy), 64'h1);
        step();
        chk("t4_rspv", 64'(rsp_valid), 64'h1);
        chk("t4_rerr", 64'(rsp_err), 64'h1);
        chk("t4_rdata", 64'(rsp_data), 64'h0);
        chk("t4_drd", 64'(mem_data_read), 64'h0);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        settle();
        chk("t4_done_busy", 64'(busy), 64'h0);
        chk("t4_done_rspv", 64'(rsp_valid), 64'h0);

        // ---------------- 5: stale out_valid in IDLE ----------------
        mem_out_valid = 1'b1;
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr[0 +: ADDR_W]  = 12'h030;
        req_wdata[0 +: DATA_W] = 32'h12345678;
        settle();
        chk("t5_no_grant", 64'(req_ready), 64'h0);
        chk("t5_idle_drd", 64'(mem_data_read), 64'h0);
        step();
        mem_out_valid = 1'b0;
        settle();
        chk("t5_flush_drd", 64'(mem_data_read), 64'h1);
        chk("t5_flush_busy", 64'(busy), 64'h1);
        chk("t5_flush_rdy", 64'(req_ready), 64'h0);
        step();
        chk("t5_grant", 64'(req_ready), 64'h1);
        chk("t5_drd_off", 64'(mem_data_read), 64'h0);
        step();
        req_valid = 2'b00;
        settle();
        chk("t5_wreq", 64'(mem_write_request), 64'h1);
        chk("t5_addr", 64'(mem_addr), 64'h030);
        chk("t5_data", 64'(mem_wdata), 64'h12345678);
        step();

        // ---------------- 6: reset in RD_WAIT ----------------
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr[ADDR_W +: ADDR_W] = 12'h040;
        settle();
        chk("t6_ready", 64'(req_ready), 64'h2);
        step();
        req_valid = 2'b00;
        settle();
        chk("t6_wait_addr", 64'(mem_addr), 64'h040);
        step();
        rst = 1'b1;
        step();
        chk_idle_outputs("t6_rst");
        rst = 1'b0;
        step();
        chk("t6_no_rsp", 64'(rsp_valid), 64'h0);
        // pointer back at 0: req0 wins even though req1 was last granted
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr[0 +: ADDR_W] = 12'h010;
        settle();
        chk("t6_ptr_reset", 64'(req_ready), 64'h1);
        step();
        req_valid = 2'b00;
        mem_out_valid = 1'b1;
        mem_data_out  = 32'hCAFEF00D;
        settle();
        chk("t6_addr", 64'(mem_addr), 64'h010);
        chk("t6_drd", 64'(mem_data_read), 64'h1);
        step();
        mem_out_valid = 1'b0;
        mem_data_out  = 32'h0;
        settle();
        chk("t6_rspv", 64'(rsp_valid), 64'h1);
        chk("t6_rdata", 64'(rsp_data), 64'hCAFEF00D);
        chk("t6_rerr", 64'(rsp_err), 64'h0);
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        settle();
        chk("t6_done_rspv", 64'(rsp_valid), 64'h0);
        chk("t6_done_busy", 64'(busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
